// File: rtl/complex_vector_chunk_streamer_pkg.sv
// complex_vector_chunk_streamer_pkg: shared widths, zero element, lane helpers and FSM encoding.
package complex_vector_chunk_streamer_pkg;
  localparam int ELEMENT_WIDTH = 64;
  localparam int NI_DEFAULT = 8;
  localparam logic [ELEMENT_WIDTH-1:0] CPLX_ZERO = '0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int lane_lsb(input int lane, input int ni, input int ew);
    return ew * (ni - 1 - lane);
  endfunction
  function automatic logic lane_live(input int chunk, input int lane, input int ni, input int noe);
    return chunk * ni + lane < noe;
  endfunction
endpackage

// File: rtl/complex_chunk_skid_fifo.sv
// complex_chunk_skid_fifo: 2-entry FIFO holding both chunk rows plus the last flag.
module complex_chunk_skid_fifo #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   occupancy
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      occupancy <= occupancy + 2'(push) - 2'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = occupancy == 2'd2;
  assign empty = occupancy == 2'd0;
endmodule

// File: rtl/complex_vector_chunk_streamer.sv
// complex_vector_chunk_streamer: reads two complex vectors chunk by chunk from RAM and streams
// zero-padded chunks with the latched constant/op over a valid/ready handshake.
module complex_vector_chunk_streamer
  import complex_vector_chunk_streamer_pkg::*;
#(
  parameter int NOE = 19,
  parameter int NI = NI_DEFAULT,
  parameter int element_width = ELEMENT_WIDTH,
  parameter int AW = 8,
  localparam int CHUNKS = (NOE + NI - 1) / NI,
  localparam int CW = $clog2(CHUNKS + 1),
  localparam int RW = element_width * NI
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AW-1:0]            base_addr,
  input  logic [element_width-1:0] constant_in,
  input  logic                     op_in,
  output logic                     busy,
  output logic                     finish,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  input  logic [RW-1:0]            rd_data_a,
  input  logic [RW-1:0]            rd_data_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RW-1:0]            out_first_row,
  output logic [RW-1:0]            out_second_row,
  output logic [element_width-1:0] out_constant,
  output logic                     out_op,
  output logic                     out_last,
  output logic [CW-1:0]            out_chunk_idx
);
  state_t state;
  logic [AW-1:0] base_r;
  logic [CW-1:0] issue_cnt, recv_cnt;
  logic rd_en_q, pop, full, empty, head_last;
  logic [1:0] occ;
  logic [RW-1:0] pad_a, pad_b;
  for (genvar j = 0; j < NI; j++) begin : g_lane
    localparam int L = lane_lsb(j, NI, element_width);
    assign pad_a[L +: element_width] = lane_live(int'(recv_cnt), j, NI, NOE) ? rd_data_a[L +: element_width] : CPLX_ZERO;
    assign pad_b[L +: element_width] = lane_live(int'(recv_cnt), j, NI, NOE) ? rd_data_b[L +: element_width] : CPLX_ZERO;
  end
  complex_chunk_skid_fifo #(.W(2 * RW + 1)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(rd_en_q & ~full),
    .pop(pop),
    .din({pad_a, pad_b, recv_cnt == CW'(CHUNKS - 1)}),
    .dout({out_first_row, out_second_row, head_last}),
    .full(full),
    .empty(empty),
    .occupancy(occ)
  );
  assign out_valid = ~empty;
  assign out_last = head_last & ~empty;
  assign pop = out_valid & out_ready;
  // Credit: FIFO entries plus the read landing this cycle, minus this cycle's pop, must stay below 2.
  assign rd_en = state == RUN && ({1'b0, occ} + {2'b0, rd_en_q} < 3'd2 + {2'b0, pop});
  assign rd_addr = base_r + AW'(issue_cnt);
  assign busy = state != IDLE;
  assign finish = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      base_r <= '0;
      out_constant <= '0;
      out_op <= 1'b0;
      issue_cnt <= '0;
      recv_cnt <= '0;
      out_chunk_idx <= '0;
      rd_en_q <= 1'b0;
    end else begin
      rd_en_q <= rd_en;
      if (rd_en) issue_cnt <= issue_cnt + 1'b1;
      if (rd_en_q) recv_cnt <= recv_cnt + 1'b1;
      if (pop) out_chunk_idx <= out_chunk_idx + 1'b1;
      case (state)
        IDLE: if (start) begin
          base_r <= base_addr;
          out_constant <= constant_in;
          out_op <= op_in;
          issue_cnt <= '0;
          recv_cnt <= '0;
          out_chunk_idx <= '0;
          state <= RUN;
        end
        RUN: if (rd_en && issue_cnt == CW'(CHUNKS - 1)) state <= DRAIN;
        DRAIN: if (pop && head_last) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_vector_chunk_streamer.sv
// tb_complex_vector_chunk_streamer: three streamer instances (NOE 19/16/1) fed by RAM models,
// checked against a beat scoreboard plus per-scenario cycle tables.
module tb_complex_vector_chunk_streamer;
  typedef struct {
    int k;
    logic [511:0] a, b;
    logic last;
    logic [1:0] idx;
    logic [63:0] cst;
    logic op;
  } beat_t;

  function automatic int noe_of(input int k);
    return k == 0 ? 19 : k == 1 ? 16 : 1;
  endfunction
  function automatic logic [63:0] elem(input logic [7:0] a, input int row, input int j);
    return {a, 8'(row), 8'(j), 8'h5a, a ^ 8'(j * 17), 8'(row + 1), 8'(j), 8'hc3};
  endfunction
  function automatic logic [511:0] ram_word(input logic [7:0] a, input int row);
    logic [511:0] w;
    for (int j = 0; j < 8; j++) w[64*(8-j)-1 -: 64] = elem(a, row, j);
    return w;
  endfunction
  function automatic logic [511:0] exp_word(input logic [7:0] b, input int c, input int row, input int noe);
    logic [511:0] w;
    w = ram_word(8'(b + c), row);
    for (int j = 0; j < 8; j++) if (c * 8 + j >= noe) w[64*(8-j)-1 -: 64] = 64'h0;
    return w;
  endfunction

  logic clk = 1'b0, reset = 1'b1;
  logic start[3], op[3], ready[3], busy[3], fin[3], rd_en[3], ov[3], olast[3], oop[3];
  logic [7:0] base[3], raddr[3];
  logic [63:0] cst[3], ocst[3];
  logic [511:0] ofr[3], osr[3];
  logic [1:0] oidx[3];
  beat_t sb[$];
  int checks = 0, errors = 0;
  logic held[3], prev_lh[3], h_l[3];
  logic [511:0] h_a[3], h_b[3];
  logic [1:0] h_i[3];
  logic [63:0] h_c[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = noe_of(g);
    localparam int CWG = $clog2((N + 7) / 8 + 1);
    logic [511:0] ra, rb;
    logic [CWG-1:0] idx_w;
    always @(posedge clk) if (rd_en[g]) begin
      ra <= ram_word(raddr[g], 0);
      rb <= ram_word(raddr[g], 1);
    end
    assign oidx[g] = 2'(idx_w);
    complex_vector_chunk_streamer #(.NOE(N)) dut (
      .clk(clk), .reset(reset), .start(start[g]), .base_addr(base[g]),
      .constant_in(cst[g]), .op_in(op[g]), .busy(busy[g]), .finish(fin[g]),
      .rd_en(rd_en[g]), .rd_addr(raddr[g]), .rd_data_a(ra), .rd_data_b(rb),
      .out_valid(ov[g]), .out_ready(ready[g]), .out_first_row(ofr[g]),
      .out_second_row(osr[g]), .out_constant(ocst[g]), .out_op(oop[g]),
      .out_last(olast[g]), .out_chunk_idx(idx_w)
    );
  end

  // Scoreboard, finish-timing and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      for (int k = 0; k < 3; k++) begin
        held[k] = 1'b0;
        prev_lh[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (fin[k] !== prev_lh[k]) begin
          errors++;
          $display("FAIL finish_timing inst %0d got %b want %b", k, fin[k], prev_lh[k]);
        end
        if (held[k]) begin
          checks++;
          if (ov[k] !== 1'b1 || ofr[k] !== h_a[k] || osr[k] !== h_b[k] || olast[k] !== h_l[k] ||
              oidx[k] !== h_i[k] || ocst[k] !== h_c[k]) begin
            errors++;
            $display("FAIL hold_stable inst %0d got valid %b idx %0d last %b want valid 1 idx %0d last %b",
                     k, ov[k], oidx[k], olast[k], h_i[k], h_l[k]);
          end
        end
        if (ov[k] && ready[k]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat inst %0d got idx %0d want no beat", k, oidx[k]);
          end else begin
            beat_t e;
            e = sb.pop_front();
            checks += 3;
            if (e.k != k || oidx[k] !== e.idx || olast[k] !== e.last || ocst[k] !== e.cst || oop[k] !== e.op) begin
              errors++;
              $display("FAIL beat_meta inst %0d got idx %0d last %b cst %h op %b want inst %0d idx %0d last %b cst %h op %b",
                       k, oidx[k], olast[k], ocst[k], oop[k], e.k, e.idx, e.last, e.cst, e.op);
            end
            if (ofr[k] !== e.a) begin
              errors++;
              $display("FAIL first_row inst %0d got %h want %h", k, ofr[k], e.a);
            end
            if (osr[k] !== e.b) begin
              errors++;
              $display("FAIL second_row inst %0d got %h want %h", k, osr[k], e.b);
            end
          end
        end
        prev_lh[k] = ov[k] && ready[k] && olast[k];
        held[k] = ov[k] && !ready[k];
        h_a[k] = ofr[k];
        h_b[k] = osr[k];
        h_l[k] = olast[k];
        h_i[k] = oidx[k];
        h_c[k] = ocst[k];
      end
    end
  end

  task automatic kick(input int k, input logic [7:0] b, input logic [63:0] c, input logic o);
    beat_t e;
    int n;
    n = (noe_of(k) + 7) / 8;
    @(posedge clk);
    #1;
    start[k] = 1'b1;
    base[k] = b;
    cst[k] = c;
    op[k] = o;
    for (int i = 0; i < n; i++) begin
      e.k = k;
      e.a = exp_word(b, i, 0, noe_of(k));
      e.b = exp_word(b, i, 1, noe_of(k));
      e.last = i == n - 1;
      e.idx = 2'(i);
      e.cst = c;
      e.op = o;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      ready[k] = 1'b1;
      base[k] = '0;
      cst[k] = '0;
      op[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy[k], fin[k], rd_en[k], ov[k], olast[k], oop[k]} !== 6'b0 || ocst[k] !== 64'h0 ||
          oidx[k] !== 2'd0 || ofr[k] !== 512'h0 || raddr[k] !== 8'h0) begin
        errors++;
        $display("FAIL reset_state inst %0d got busy %b fin %b rd_en %b valid %b last %b op %b cst %h want all 0",
                 k, busy[k], fin[k], rd_en[k], ov[k], olast[k], oop[k], ocst[k]);
      end
    end
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic test_basic();
    kick(0, 8'h10, 64'h4000_0000_c0a0_0000, 1'b1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      checks++;
      if (rd_en[0] !== (cyc <= 3) || ov[0] !== (cyc >= 3 && cyc <= 5) || fin[0] !== (cyc == 6) ||
          busy[0] !== (cyc <= 6) || (cyc <= 3 && raddr[0] !== 8'(8'h10 + cyc - 1))) begin
        errors++;
        $display("FAIL basic_cycle %0d got rd_en %b addr %h valid %b fin %b busy %b want rd_en %b addr %h valid %b fin %b busy %b",
                 cyc, rd_en[0], raddr[0], ov[0], fin[0], busy[0], cyc <= 3, 8'(8'h10 + cyc - 1),
                 cyc >= 3 && cyc <= 5, cyc == 6, cyc <= 6);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_beats_left got %0d want 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    int nrd, n;
    nrd = 0;
    ready[0] = 1'b0;
    kick(0, 8'h20, 64'h3f00_0000_bf00_0000, 1'b0);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (rd_en[0]) nrd++;
      checks++;
      if (ov[0] !== (cyc >= 3)) begin
        errors++;
        $display("FAIL bp_valid cycle %0d got %b want %b", cyc, ov[0], cyc >= 3);
      end
    end
    checks++;
    if (nrd != 2) begin
      errors++;
      $display("FAIL bp_reads got %0d want 2", nrd);
    end
    @(posedge clk);
    #1 ready[0] = 1'b1;
    n = 0;
    while (fin[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fin[0] !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_complete got finish %b beats_left %0d want finish 1 beats_left 0", fin[0], sb.size());
    end
  endtask

  task automatic test_short_wrap();
    kick(1, 8'hff, 64'h1234_5678_9abc_def0, 1'b1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      checks++;
      if (rd_en[1] !== (cyc <= 2) || ov[1] !== (cyc == 3 || cyc == 4) || fin[1] !== (cyc == 5) ||
          (cyc <= 2 && raddr[1] !== 8'(8'hff + cyc - 1))) begin
        errors++;
        $display("FAIL short_cycle %0d got rd_en %b addr %h valid %b fin %b want rd_en %b addr %h valid %b fin %b",
                 cyc, rd_en[1], raddr[1], ov[1], fin[1], cyc <= 2, 8'(8'hff + cyc - 1), cyc == 3 || cyc == 4, cyc == 5);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL short_beats_left got %0d want 0", sb.size());
    end
  endtask

  task automatic test_restart_ignored();
    int n;
    kick(0, 8'h40, 64'h4000_0000_c0a0_0000, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    start[0] = 1'b1;
    cst[0] = 64'h3f80_0000_0000_0000;
    op[0] = 1'b0;
    @(posedge clk);
    #1 start[0] = 1'b0;
    n = 0;
    while (fin[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fin[0] !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL restart_complete got finish %b beats_left %0d want finish 1 beats_left 0", fin[0], sb.size());
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || ocst[0] !== 64'h4000_0000_c0a0_0000 || oop[0] !== 1'b1) begin
        errors++;
        $display("FAIL restart_latched got busy %b cst %h op %b want busy 0 cst 40000000c0a00000 op 1",
                 busy[0], ocst[0], oop[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    kick(0, 8'h50, 64'h0123_4567_89ab_cdef, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got valid %b busy %b rd_en %b want 0 0 0", ov[0], busy[0], rd_en[0]);
    end
    sb.delete();
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    kick(0, 8'h60, 64'h4120_0000_4130_0000, 1'b1);
    n = 0;
    while (fin[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 40 || busy[0] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset_run got waited %0d busy %b beats_left %0d want finish busy 0 beats_left 0",
               n, busy[0], sb.size());
    end
  endtask

  task automatic test_single();
    kick(2, 8'h7f, 64'hc2c8_0000_42c8_0000, 1'b0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (rd_en[2] !== (cyc == 1) || ov[2] !== (cyc == 3) || olast[2] !== (cyc == 3) || fin[2] !== (cyc == 4)) begin
        errors++;
        $display("FAIL single_cycle %0d got rd_en %b valid %b last %b fin %b want %b %b %b %b",
                 cyc, rd_en[2], ov[2], olast[2], fin[2], cyc == 1, cyc == 3, cyc == 3, cyc == 4);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_beats_left got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_wrap();
    test_restart_ignored();
    test_async_reset();
    test_single();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
